ex_mem_stage: RTL and testbench

Execute-to-memory pipeline stage that sits directly downstream of the 64-bit ALU. It captures `result`/`zero` and the instruction's side-band control into a two-entry skid buffer with a valid/ready handshake toward the memory stage. It also resolves branches from the ALU's compare outputs and issues a registered one-cycle PC redirect plus wrong-path squash.

---
 rtl/ex_mem_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: two-entry skid buffer, branch resolve, one-cycle redirect/squash.
// Define EX_MEM_BRANCH_STATS_EN to build the branch statistics counters.
module ex_mem_stage #(
    parameter int N  = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [N-1:0]  ex_result,
    input  logic          ex_zero,
    input  logic [N-1:0]  ex_pc,
    input  logic [N-1:0]  ex_imm,
    input  logic [1:0]    ex_br_cond,
    input  logic          ex_jump,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [N-1:0]  ex_store_data,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [N-1:0]  mem_result,
    output logic [N-1:0]  mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic          redirect,
    output logic [N-1:0]  redirect_pc,
    output logic [31:0]   br_count,
    output logic [31:0]   br_taken_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [N-1:0]  result;
        logic [N-1:0]  store_data;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } ent_t;

    state_t state, state_n;
    ent_t   in_ent, main_q, skid_q;
    logic   in_xfer, out_xfer, accept, taken;
    logic   ld_main_in, ld_main_skid, ld_skid;

    assign ex_ready  = (state != TWO);
    assign mem_valid = (state != EMPTY);
    assign in_xfer   = ex_valid && ex_ready;
    assign out_xfer  = mem_valid && mem_ready;
    // Transfers taken while a redirect is out are wrong-path and dropped.
    assign accept    = in_xfer && !redirect;

    assign in_ent.result     = ex_result;
    assign in_ent.store_data = ex_store_data;
    assign in_ent.rd         = ex_rd;
    assign in_ent.reg_write  = ex_reg_write;
    assign in_ent.mem_read   = ex_mem_read;
    assign in_ent.mem_write  = ex_mem_write;

    always_comb begin
        taken = ex_jump;
        case (ex_br_cond)
            2'b01:   taken = taken | ex_zero;
            2'b10:   taken = taken | !ex_zero;
            2'b11:   taken = taken | ex_result[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_n    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && out_xfer) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    state_n = TWO;
                    ld_skid = 1'b1;
                end else if (out_xfer) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_n      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_ent;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= in_ent;
        end
    end

    assign mem_result     = main_q.result;
    assign mem_store_data = main_q.store_data;
    assign mem_rd         = main_q.rd;
    assign mem_reg_write  = main_q.reg_write;
    assign mem_mem_read   = main_q.mem_read;
    assign mem_mem_write  = main_q.mem_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= accept && taken;
            if (accept && taken) redirect_pc <= ex_pc + ex_imm;
        end
    end

`ifdef EX_MEM_BRANCH_STATS_EN
    logic [31:0] brc, brtc;
    logic        br_any;

    assign br_any = ex_jump || (ex_br_cond != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            brc  <= '0;
            brtc <= '0;
        end else if (accept && br_any) begin
            if (brc != 32'hFFFF_FFFF)            brc  <= brc + 32'd1;
            if (taken && brtc != 32'hFFFF_FFFF)  brtc <= brtc + 32'd1;
        end
    end

    assign br_count       = brc;
    assign br_taken_count = brtc;
`else
    assign br_count       = '0;
    assign br_taken_count = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed plan plus random traffic vs a queue model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_result;
    logic        ex_zero;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic [1:0]  ex_br_cond;
    logic        ex_jump;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [63:0] ex_store_data;
    logic        mem_valid, mem_ready;
    logic [63:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] br_count, br_taken_count;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_zero(ex_zero),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_br_cond(ex_br_cond), .ex_jump(ex_jump),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .br_count(br_count), .br_taken_count(br_taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v, mr, z, j, rw, mrd, mwr;
        logic [63:0] res, pc, imm, sd;
        logic [1:0]  cond;
        logic [4:0]  rd;
    } stim_t;

    typedef struct {
        logic [63:0] res, sd;
        logic [4:0]  rd;
        logic        rw, mrd, mwr;
    } ent_t;

    ent_t        q[$];
    logic        m_redir;
    logic [63:0] m_rpc;
    int unsigned m_brc, m_brtc;
    int          n_chk = 0;
    int          n_pass = 0;
    stim_t       s;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_model();
        chk("ex_ready", ex_ready, q.size() < 2);
        chk("mem_valid", mem_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("mem_result", mem_result, q[0].res);
            chk("mem_store_data", mem_store_data, q[0].sd);
            chk("mem_rd", mem_rd, q[0].rd);
            chk("mem_ctl", {mem_reg_write, mem_mem_read, mem_mem_write},
                {q[0].rw, q[0].mrd, q[0].mwr});
        end
        chk("redirect", redirect, m_redir);
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef EX_MEM_BRANCH_STATS_EN
        chk("br_count", br_count, m_brc);
        chk("br_taken_count", br_taken_count, m_brtc);
`else
        chk("br_count", br_count, 0);
        chk("br_taken_count", br_taken_count, 0);
`endif
    endtask

    function automatic stim_t idle(input logic mr);
        stim_t t;
        t = '{default: '0};
        t.mr = mr;
        return t;
    endfunction

    task automatic step(input stim_t t);
        bit   in_x, out_x, tk, br;
        ent_t e;
        check_model();
        reset = t.rst; ex_valid = t.v; mem_ready = t.mr;
        ex_result = t.res; ex_zero = t.z; ex_pc = t.pc; ex_imm = t.imm;
        ex_br_cond = t.cond; ex_jump = t.j; ex_rd = t.rd;
        ex_reg_write = t.rw; ex_mem_read = t.mrd; ex_mem_write = t.mwr;
        ex_store_data = t.sd;
        if (t.rst) begin
            q.delete();
            m_redir = 0; m_rpc = 0; m_brc = 0; m_brtc = 0;
        end else begin
            in_x  = t.v && (q.size() < 2);
            out_x = (q.size() > 0) && t.mr;
            if (out_x) void'(q.pop_front());
            if (in_x && !m_redir) begin
                e.res = t.res; e.sd = t.sd; e.rd = t.rd;
                e.rw = t.rw; e.mrd = t.mrd; e.mwr = t.mwr;
                q.push_back(e);
                tk = t.j || (t.cond == 2'd1 && t.z) ||
                     (t.cond == 2'd2 && !t.z) || (t.cond == 2'd3 && t.res[0]);
                br = t.j || (t.cond != 2'd0);
                if (br) m_brc++;
                if (br && tk) m_brtc++;
                m_redir = tk;
                if (tk) m_rpc = t.pc + t.imm;
            end else begin
                m_redir = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        q.delete();
        m_redir = 0; m_rpc = 0; m_brc = 0; m_brtc = 0;
        s = idle(1'b0);
        s.rst = 1'b1;
        reset = 1'b1; ex_valid = 0; mem_ready = 0; ex_result = 0;
        ex_zero = 0; ex_pc = 0; ex_imm = 0; ex_br_cond = 0; ex_jump = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_store_data = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_redirect", {redirect, redirect_pc}, 0);
        chk("rst_mem_data", {mem_result, mem_store_data, mem_rd}, 0);
        chk("rst_mem_ctl", {mem_reg_write, mem_mem_read, mem_mem_write}, 0);
        step(s);

        s = idle(1); s.v = 1; s.res = 3; s.rd = 5; s.rw = 1;
        step(s);
        chk("add_valid", mem_valid, 1);
        chk("add_result", mem_result, 3);
        chk("add_rd", mem_rd, 5);
        chk("add_noredir", redirect, 0);
        step(idle(1));

        s = idle(0); s.v = 1; s.res = 10; step(s);
        s.res = 11; step(s);
        chk("skid_full", ex_ready, 0);
        chk("skid_head", mem_result, 10);
        s.res = 12; step(s);
        s.mr = 1; step(s);
        chk("drain_11", mem_result, 11);
        chk("drain_ready", ex_ready, 1);
        step(s);
        chk("accept_12", mem_result, 12);
        step(idle(1));

        s = idle(1); s.v = 1; s.res = 1; s.cond = 2'd3;
        s.pc = 64'h100; s.imm = -64'sd8;
        step(s);
        chk("lt_redirect", redirect, 1);
        chk("lt_target", redirect_pc, 64'hF8);
        s = idle(1); s.v = 1; s.res = 77; s.rd = 7; s.rw = 1;
        s.cond = 2'd1; s.z = 1;
        step(s);
        chk("squash_pulse", redirect, 0);
        chk("squash_drop", mem_valid, 0);

        s = idle(1); s.v = 1; s.cond = 2'd2; s.z = 1;
        step(s);
        chk("bne_nottaken", redirect, 0);
        s.cond = 2'd1; s.pc = 64'hFFFF_FFFF_FFFF_FFFC; s.imm = 64'h8;
        step(s);
        chk("beq_wrap", {63'd0, redirect}, 1);
        chk("beq_wrap_pc", redirect_pc, 64'h4);
        step(idle(1));

        s = idle(0); s.v = 1; s.res = 20; step(s);
        s.j = 1; s.pc = 64'h2000; s.imm = 64'h40; step(s);
`ifdef EX_MEM_BRANCH_STATS_EN
        chk("stat_br", br_count, 4);
        chk("stat_taken", br_taken_count, 3);
`endif
        s = idle(0); s.rst = 1; s.v = 1; step(s);
        chk("midrst_valid", mem_valid, 0);
        chk("midrst_ready", ex_ready, 1);
        chk("midrst_redir", redirect, 0);

        for (int i = 0; i < 600; i++) begin
            s.rst  = ($urandom_range(0, 79) == 0);
            s.v    = ($urandom_range(0, 3) != 0);
            s.mr   = ($urandom_range(0, 2) != 0);
            s.res  = {$urandom, $urandom};
            s.z    = $urandom_range(0, 1);
            s.pc   = {$urandom, $urandom};
            s.imm  = {{32{1'b0}}, $urandom};
            s.cond = $urandom_range(0, 3);
            s.j    = ($urandom_range(0, 7) == 0);
            s.rd   = $urandom_range(0, 31);
            s.rw   = $urandom_range(0, 1);
            s.mrd  = $urandom_range(0, 1);
            s.mwr  = $urandom_range(0, 1);
            s.sd   = {$urandom, $urandom};
            step(s);
        end
        check_model();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
